// File: rtl/df_mac_accumulator.sv
// df_mac_accumulator: sums TAPS multiplier products into one filter sample.
// Optional DF_MAC_SATURATE_EN clips the result instead of wrapping it.
module df_mac_accumulator #(
    parameter int TAPS = 4,
    parameter int DW   = 8,
    parameter int OW   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    prod_valid,
    input  logic [DW-1:0]           prod,
    output logic [$clog2(TAPS)-1:0] tap_sel,
    output logic                    busy,
    output logic                    out_valid,
    output logic [OW-1:0]           out,
    output logic                    sat
);

    localparam int SELW = $clog2(TAPS);
    localparam int AW   = DW + $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic          last;
    logic          launch;
    logic [OW-1:0] out_nxt;

    assign sum    = acc + AW'(prod);
    assign last   = (state == ACC) && prod_valid
                 && (tap_sel == SELW'(TAPS - 1));
    assign launch = (state != ACC) && start;

    assign busy      = (state == ACC);
    assign out_valid = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start is only honoured outside ACC
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? ACC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator and tap index: clear on launch, advance per product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            tap_sel <= '0;
        end else if (launch) begin
            acc     <= '0;
            tap_sel <= '0;
        end else if (busy && prod_valid) begin
            acc     <= sum;
            tap_sel <= last ? '0 : tap_sel + SELW'(1);
        end
    end

`ifdef DF_MAC_SATURATE_EN
    logic sat_nxt;

    if (OW >= AW) begin : g_wide
        // Result always fits: zero-extend, never clipped
        always_comb begin
            out_nxt = OW'(sum);
            sat_nxt = 1'b0;
        end
    end else begin : g_narrow
        // Clip to full scale when any dropped bit is set
        always_comb begin
            sat_nxt = |sum[AW-1:OW];
            out_nxt = sat_nxt ? '1 : sum[OW-1:0];
        end
    end

    // Saturation flag travels with the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (last) begin
            sat <= sat_nxt;
        end
    end
`else
    if (OW >= AW) begin : g_wide
        // Result always fits: zero-extend
        always_comb begin
            out_nxt = OW'(sum);
        end
    end else begin : g_narrow
        // Wrap-around: keep the low bits
        always_comb begin
            out_nxt = sum[OW-1:0];
        end
    end

    assign sat = 1'b0;
`endif

    // Result register: loads only at the last-tap edge, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (last) begin
            out <= out_nxt;
        end
    end

endmodule

// File: tb/tb_df_mac_accumulator.sv
// tb_df_mac_accumulator: scoreboard bench for df_mac_accumulator.
// Expected samples are queued at stimulus time and popped on out_valid.
module tb_df_mac_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       prod_valid = 1'b0;
    logic [7:0] prod = '0;
    logic [1:0] tap_sel;
    logic       busy;
    logic       out_valid;
    logic [7:0] out;
    logic       sat;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] exp_q[$];

    df_mac_accumulator #(
        .TAPS(4),
        .DW(8),
        .OW(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .prod_valid(prod_valid),
        .prod(prod),
        .tap_sel(tap_sel),
        .busy(busy),
        .out_valid(out_valid),
        .out(out),
        .sat(sat)
    );

    always #5 clk = ~clk;

    // Reference width reduction of a full sum: {sat, out}
    function automatic logic [8:0] model(input int s);
`ifdef DF_MAC_SATURATE_EN
        if (s > 255) return {1'b1, 8'hFF};
        return {1'b0, s[7:0]};
`else
        return {1'b0, s[7:0]};
`endif
    endfunction

    // Drive one sample (4 products, gap idle cycles between them),
    // push its expected result, stop at the out_valid cycle.
    task automatic drive_sample(
        input  logic [7:0] p0, p1, p2, p3,
        input  int         gap,
        input  bit         pulse,
        output int         lat,
        output bit         tsel_ok,
        output bit         busy_ok
    );
        logic [7:0] p[4];
        int edges;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        exp_q.push_back(model(int'(p0) + int'(p1) + int'(p2) + int'(p3)));
        tsel_ok = 1'b1;
        busy_ok = 1'b1;
        lat = -1;
        @(negedge clk);
        start = 1'b1;
        prod_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        for (int i = 0; i < 4; i++) begin
            if (tap_sel !== 2'(i)) tsel_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            prod_valid = 1'b1;
            prod = p[i];
            @(negedge clk);
            edges++;
            prod_valid = 1'b0;
            prod = '0;
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    if (tap_sel !== 2'(i + 1)) tsel_ok = 1'b0;
                    if (busy !== 1'b1) busy_ok = 1'b0;
                    start = (pulse && g == 0);
                    @(negedge clk);
                    edges++;
                end
                start = 1'b0;
            end
        end
        for (int w = 0; w < 40; w++) begin
            if (out_valid === 1'b1) begin
                lat = edges;
                break;
            end
            @(negedge clk);
            edges++;
        end
        if (tap_sel !== 2'd0) tsel_ok = 1'b0;
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset;
        int lat;
        bit tok, bok, seen;
        logic [8:0] e;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({tap_sel, busy, out_valid, out, sat} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_init: got %h want 0",
                     {tap_sel, busy, out_valid, out, sat});
        end
        rst_n = 1'b1;
        drive_sample(8'h10, 8'h20, 8'h30, 8'h40, 0, 1'b0, lat, tok, bok);
        e = exp_q.pop_front();
        n_cmp++;
        if ({sat, out} !== e) begin
            n_err++;
            $display("FAIL reset_pre_sample: got %h want %h", {sat, out}, e);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1;
            prod = 8'h11;
            @(negedge clk);
        end
        prod_valid = 1'b0;
        n_cmp++;
        if (tap_sel !== 2'd2 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_setup: tap_sel %0d busy %b want 2 1",
                     tap_sel, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tap_sel, busy, out_valid, out, sat} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_async: got %h want 0",
                     {tap_sel, busy, out_valid, out, sat});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            prod_valid = 1'b1;
            prod = 8'h22;
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        prod_valid = 1'b0;
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_no_result: activity after reset, want none");
        end
    endtask

    task automatic test_basic;
        int lat;
        bit tok, bok;
        logic [8:0] e;
        drive_sample(8'h10, 8'h20, 8'h30, 8'h40, 0, 1'b0, lat, tok, bok);
        n_cmp++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL basic_latency: got %0d want 4", lat);
        end
        n_cmp++;
        if (!tok || !bok) begin
            n_err++;
            $display("FAIL basic_seq: tap_sel_ok %b busy_ok %b want 1 1",
                     tok, bok);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({sat, out} !== e || e !== 9'h0A0) begin
            n_err++;
            $display("FAIL basic_sum: got %h want %h", {sat, out}, 9'h0A0);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_strobe: out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_overflow;
        int lat;
        bit tok, bok;
        logic [8:0] e;
        drive_sample(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1'b0, lat, tok, bok);
        e = exp_q.pop_front();
        n_cmp++;
        if ({sat, out} !== e) begin
            n_err++;
            $display("FAIL overflow: got %h want %h", {sat, out}, e);
        end
    endtask

    task automatic test_stalls;
        int lat;
        bit tok, bok;
        logic [8:0] e;
        drive_sample(8'h10, 8'h20, 8'h30, 8'h40, 2, 1'b0, lat, tok, bok);
        n_cmp++;
        if (lat !== 10) begin
            n_err++;
            $display("FAIL stall_latency: got %0d want 10", lat);
        end
        n_cmp++;
        if (!tok || !bok) begin
            n_err++;
            $display("FAIL stall_seq: tap_sel_ok %b busy_ok %b want 1 1",
                     tok, bok);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({sat, out} !== e) begin
            n_err++;
            $display("FAIL stall_sum: got %h want %h", {sat, out}, e);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        int extra;
        bit tok, bok;
        logic [8:0] e;
        drive_sample(8'h05, 8'h06, 8'h07, 8'h08, 1, 1'b1, lat, tok, bok);
        n_cmp++;
        if (lat !== 7) begin
            n_err++;
            $display("FAIL ignore_latency: got %0d want 7", lat);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({sat, out} !== e) begin
            n_err++;
            $display("FAIL ignore_sum: got %h want %h", {sat, out}, e);
        end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL ignore_single: extra activity %0d want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] p[4];
        logic [8:0] e;
        p[0] = 8'h10; p[1] = 8'h20; p[2] = 8'h30; p[3] = 8'h40;
        exp_q.push_back(model(32'hA0));
        exp_q.push_back(model(4));
        @(negedge clk);
        start = 1'b1;
        prod_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            prod_valid = 1'b1;
            prod = p[i];
            @(negedge clk);
        end
        prod_valid = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {sat, out} !== e) begin
            n_err++;
            $display("FAIL b2b_first: valid %b got %h want 1 %h",
                     out_valid, {sat, out}, e);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || tap_sel !== 2'd0) begin
            n_err++;
            $display("FAIL b2b_reenter: busy %b tap_sel %0d want 1 0",
                     busy, tap_sel);
        end
        for (int i = 0; i < 4; i++) begin
            prod_valid = 1'b1;
            prod = 8'h01;
            @(negedge clk);
        end
        prod_valid = 1'b0;
        start = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {sat, out} !== e) begin
            n_err++;
            $display("FAIL b2b_second: valid %b got %h want 1 %h",
                     out_valid, {sat, out}, e);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: valid %b busy %b want 0 0",
                     out_valid, busy);
        end
    endtask

    task automatic test_random;
        int lat;
        bit tok, bok;
        logic [7:0] r[4];
        logic [8:0] e;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++) r[i] = 8'($urandom_range(0, 255));
            drive_sample(r[0], r[1], r[2], r[3], n, 1'b0, lat, tok, bok);
            e = exp_q.pop_front();
            n_cmp++;
            if ({sat, out} !== e || lat !== 4 + 3 * n) begin
                n_err++;
                $display("FAIL random_%0d: got %h lat %0d want %h lat %0d",
                         n, {sat, out}, lat, e, 4 + 3 * n);
            end
        end
    endtask

    task automatic test_hold;
        int lat;
        int bad;
        bit tok, bok;
        logic [8:0] e;
        drive_sample(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1'b0, lat, tok, bok);
        e = exp_q.pop_front();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({sat, out} !== e || out_valid !== 1'b0
                || tap_sel !== 2'd0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL hold: %0d bad cycles, out %h want %h",
                     bad, {sat, out}, e);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_stalls();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_hold();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: %0d results left, want 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
